piso_shift_tx: RTL and testbench

PISO_SHIFT_TX -- requirements
Module: piso_shift_tx

---
 rtl/piso_shift_tx.sv | 43 ++++
 tb/tb_piso_shift_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_tx.sv
// piso_shift_tx: parallel-in serial-out transmitter, MSB first, with valid/ready word intake
module piso_shift_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0] cnt;
  logic last;
  assign last = state == SHIFT && cnt == CW'(WIDTH - 1);
  assign din_ready = !reset && (state == IDLE || last);
  // sr is all-zero whenever the FSM is idle, so its MSB doubles as a clean dout
  assign dout = sr[WIDTH-1];
  assign dout_valid = state == SHIFT;
  assign frame = state == SHIFT && cnt == '0;
  assign done = last;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sr <= '0;
      cnt <= '0;
    end else if (din_valid && din_ready) begin
      state <= SHIFT;
      sr <= din;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sr <= sr << 1;
      cnt <= last ? '0 : cnt + 1'b1;
      state <= last ? IDLE : SHIFT;
    end
  end
endmodule

// File: tb/tb_piso_shift_tx.sv
// tb_piso_shift_tx: directed and randomized checks of piso_shift_tx with a reassembling receiver
module tb_piso_shift_tx;
  localparam int W = 8;
  logic clk = 0, reset = 1, din_valid = 0;
  logic [W-1:0] din = '0;
  logic din_ready, dout, dout_valid, frame, done;
  int total = 0, bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_word = '0;
  int rx_n = 0;

  piso_shift_tx #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .frame(frame), .done(done)
  );

  always #5 clk = ~clk;

  // serial-to-parallel receiver: rebuilds words between frame and done
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (dout_valid) begin
      if (frame) rx_n = 0;
      rx_word = {rx_word[W-2:0], dout};
      rx_n++;
      if (done) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rx_unexpected got=%h", rx_word);
        end else begin
          e = exp_q.pop_front();
          if (rx_word !== e || rx_n !== W) begin
            bad++;
            $display("FAIL rx_word got=%h bits=%0d exp=%h bits=%0d", rx_word, rx_n, e, W);
          end
        end
        rx_n = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL %s_drain left=%0d exp=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1;
    din_valid = 1;
    din = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({dout_valid, dout, frame, done, din_ready} !== 5'b00000) begin
        bad++;
        $display("FAIL reset_outs got=%b exp=00000", {dout_valid, dout, frame, done, din_ready});
      end
    end
    reset = 0;
    din_valid = 0;
    #1;
    total++;
    if (din_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b exp=1", din_ready);
    end
    tick();
    total++;
    if ({dout_valid, dout, frame, done, din_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_valid_ignored got=%b exp=00001", {dout_valid, dout, frame, done, din_ready});
    end
  endtask

  task automatic test_single();
    logic [W-1:0] w = 8'hA5;
    logic [4:0] e;
    din = w;
    din_valid = 1;
    exp_q.push_back(w);
    tick();
    din_valid = 0;
    din = 8'h00;
    for (int k = 0; k < W; k++) begin
      e = {1'b1, w[W-1-k], k == 0, k == W - 1, k == W - 1};
      total++;
      if ({dout_valid, dout, frame, done, din_ready} !== e) begin
        bad++;
        $display("FAIL single_bit%0d got=%b exp=%b", k, {dout_valid, dout, frame, done, din_ready}, e);
      end
      tick();
    end
    total++;
    if ({dout_valid, dout, frame, done, din_ready} !== 5'b00001) begin
      bad++;
      $display("FAIL single_idle got=%b exp=00001", {dout_valid, dout, frame, done, din_ready});
    end
    check_drained("single");
  endtask

  task automatic test_back_to_back();
    logic [3:0] e;
    din = 8'hFF;
    din_valid = 1;
    exp_q.push_back(8'hFF);
    tick();
    din = 8'h00;
    exp_q.push_back(8'h00);
    for (int k = 0; k < 2 * W; k++) begin
      e = {1'b1, k < W, k % W == 0, k % W == W - 1};
      total++;
      if ({dout_valid, dout, frame, done} !== e) begin
        bad++;
        $display("FAIL b2b_cycle%0d got=%b exp=%b", k, {dout_valid, dout, frame, done}, e);
      end
      tick();
      if (k == W - 1) din_valid = 0;
    end
    total++;
    if ({dout_valid, dout} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_idle got=%b exp=00", {dout_valid, dout});
    end
    check_drained("b2b");
  endtask

  task automatic test_stall();
    for (int j = 0; j < 3 * W; j++) begin
      din = W'($urandom);
      din_valid = 1;
      if (j % W == 0) exp_q.push_back(din);
      tick();
      total++;
      if ({dout_valid, din_ready} !== {1'b1, j % W == W - 1}) begin
        bad++;
        $display("FAIL stall_ready%0d got=%b exp=%b", j, {dout_valid, din_ready}, {1'b1, j % W == W - 1});
      end
    end
    din_valid = 0;
    din = 8'hEE;
    tick();
    total++;
    if ({dout_valid, din_ready} !== 2'b01) begin
      bad++;
      $display("FAIL stall_idle got=%b exp=01", {dout_valid, din_ready});
    end
    check_drained("stall");
  endtask

  task automatic test_reset_mid();
    din = 8'hC3;
    din_valid = 1;
    tick();
    din_valid = 0;
    tick();
    tick();
    reset = 1;
    din_valid = 1;
    #1;
    total++;
    if (din_ready !== 1'b0) begin
      bad++;
      $display("FAIL rmid_ready got=%b exp=0", din_ready);
    end
    tick();
    total++;
    if ({dout_valid, dout, frame, done} !== 4'b0000) begin
      bad++;
      $display("FAIL rmid_flush got=%b exp=0000", {dout_valid, dout, frame, done});
    end
    reset = 0;
    din = 8'h96;
    exp_q.push_back(8'h96);
    tick();
    din_valid = 0;
    total++;
    if ({dout_valid, dout, frame} !== 3'b111) begin
      bad++;
      $display("FAIL rmid_restart got=%b exp=111", {dout_valid, dout, frame});
    end
    repeat (W + 1) tick();
    check_drained("rmid");
  endtask

  task automatic test_random();
    logic acc;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 4)) begin
        din_valid = 0;
        din = W'($urandom);
        tick();
      end
      din = W'($urandom);
      din_valid = 1;
      exp_q.push_back(din);
      acc = 0;
      for (int t = 0; t < 2 * W && !acc; t++) begin
        acc = din_ready;
        tick();
      end
      if (!acc) begin
        total++;
        bad++;
        $display("FAIL rand_accept_timeout word=%0d exp=accepted", i);
      end
    end
    din_valid = 0;
    repeat (W + 2) tick();
    check_drained("rand");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
